// File: rtl/mem_pkg.sv
// Shared constants for the data-memory load/store controller:
// RV32I width codes, FSM state encoding and byte-enable patterns.
package mem_pkg;

    // RV32I load/store width codes (func3)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size is carried in func3[1:0]; bit 2 selects zero extension
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Byte-enable patterns (byte pattern is shifted by the address offset)
    localparam logic [3:0] BE_B    = 4'b0001;
    localparam logic [3:0] BE_H_LO = 4'b0011;
    localparam logic [3:0] BE_H_HI = 4'b1100;
    localparam logic [3:0] BE_W    = 4'b1111;

    // Undefined codes are 011/110/111; unsigned variants make no sense on a store
    function automatic logic f3_illegal(input logic [2:0] f3, input logic is_store);
        return (f3[1:0] == 2'b11) || (f3[2] && (is_store || f3[1]));
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: byte enables, store-data replication,
// alignment/encoding fault detection and load-data extraction.
module mem_align
    import mem_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic        is_store,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic        fault,
    output logic [31:0] rdata_ext
);

    logic [1:0]  size;
    logic        misaligned;
    logic        sign_ext;
    logic [31:0] shifted;

    assign size     = func3[1:0];
    assign sign_ext = ~func3[2];

    // Halfwords need an even address, words a 4-byte aligned one
    assign misaligned = ((size == SZ_H) && addr_lo[0]) ||
                        ((size == SZ_W) && (addr_lo != 2'b00));
    assign fault      = f3_illegal(func3, is_store) || misaligned;

    // Byte-enable pattern for the addressed lanes
    always_comb begin
        be = BE_W;
        case (size)
            SZ_B:    be = BE_B << addr_lo;
            SZ_H:    be = addr_lo[1] ? BE_H_HI : BE_H_LO;
            default: be = BE_W;
        endcase
    end

    // Store data is replicated so the addressed lanes always carry it
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wdata_lane[gi*8 +: 8] =
                (size == SZ_B) ? wdata[7:0] :
                (size == SZ_H) ? wdata[(gi % 2)*8 +: 8] :
                                 wdata[gi*8 +: 8];
        end
    endgenerate

    // Bring the addressed byte/half down to bit 0; aligned words shift by zero
    assign shifted = rdata >> {addr_lo, 3'b000};

    // Sign- or zero-extend the selected field
    always_comb begin
        rdata_ext = shifted;
        case (size)
            SZ_B:    rdata_ext = {{24{sign_ext & shifted[7]}},  shifted[7:0]};
            SZ_H:    rdata_ext = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            default: rdata_ext = shifted;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store controller: latches one core request, drives a registered
// req/ack bus transaction with a watchdog, returns extended load data.
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_rd,
    input  logic        core_wr,
    input  logic [2:0]  core_func3,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic [31:0] core_rdata,
    output logic        core_ready,
    output logic        core_err,
    output logic        busy,
    output logic        bus_req,
    output logic        bus_we,
    output logic [29:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    // Counter wide enough to hold TIMEOUT_CYCLES-1 and still saturate cleanly
    localparam int          CW       = $clog2(TIMEOUT_CYCLES + 2);
    localparam bit          WD_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    state_t        state_reg,     state_next;
    logic [2:0]    func3_reg,     func3_next;
    logic [1:0]    addr_lo_reg,   addr_lo_next;
    logic          err_reg,       err_next;
    logic          bus_req_reg,   bus_req_next;
    logic          bus_we_reg,    bus_we_next;
    logic [29:0]   bus_addr_reg,  bus_addr_next;
    logic [3:0]    bus_be_reg,    bus_be_next;
    logic [31:0]   bus_wdata_reg, bus_wdata_next;
    logic [31:0]   rdata_reg,     rdata_next;
    logic [CW-1:0] cnt_reg,       cnt_next;

    logic          is_idle;
    logic [2:0]    al_func3;
    logic [1:0]    al_addr_lo;
    logic          al_store;
    logic [3:0]    al_be;
    logic [31:0]   al_wdata;
    logic          al_fault;
    logic [31:0]   al_rdata;
    logic          wd_expire;

    assign is_idle = (state_reg == IDLE);

    // In IDLE the lane logic looks at the live request; afterwards at the latched one
    assign al_func3   = is_idle ? core_func3      : func3_reg;
    assign al_addr_lo = is_idle ? core_addr[1:0]  : addr_lo_reg;
    assign al_store   = is_idle ? core_wr         : bus_we_reg;

    mem_align u_align (
        .func3      (al_func3),
        .addr_lo    (al_addr_lo),
        .is_store   (al_store),
        .wdata      (core_wdata),
        .rdata      (bus_rdata),
        .be         (al_be),
        .wdata_lane (al_wdata),
        .fault      (al_fault),
        .rdata_ext  (al_rdata)
    );

    // Watchdog fires on the last permitted REQ cycle
    assign wd_expire = WD_EN && (cnt_reg == CNT_LAST);

    // Next-state and next-register logic
    always_comb begin
        state_next     = state_reg;
        func3_next     = func3_reg;
        addr_lo_next   = addr_lo_reg;
        err_next       = err_reg;
        bus_req_next   = bus_req_reg;
        bus_we_next    = bus_we_reg;
        bus_addr_next  = bus_addr_reg;
        bus_be_next    = bus_be_reg;
        bus_wdata_next = bus_wdata_reg;
        rdata_next     = rdata_reg;
        cnt_next       = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (core_rd || core_wr) begin
                    func3_next   = core_func3;
                    addr_lo_next = core_addr[1:0];
                    if ((core_rd && core_wr) || al_fault) begin
                        err_next   = 1'b1;
                        state_next = RESP;
                    end else begin
                        err_next       = 1'b0;
                        state_next     = REQ;
                        bus_req_next   = 1'b1;
                        bus_we_next    = core_wr;
                        bus_addr_next  = core_addr[31:2];
                        bus_be_next    = al_be;
                        bus_wdata_next = al_wdata;
                        cnt_next       = '0;
                    end
                end
            end
            REQ: begin
                // An ack on the final watchdog cycle still completes the access
                if (bus_ack) begin
                    bus_req_next = 1'b0;
                    state_next   = RESP;
                    if (!bus_we_reg) begin
                        rdata_next = al_rdata;
                    end
                end else if (wd_expire) begin
                    bus_req_next = 1'b0;
                    err_next     = 1'b1;
                    state_next   = RESP;
                end else if (cnt_reg != CNT_MAX) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next   = IDLE;
                bus_req_next = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            func3_reg     <= '0;
            addr_lo_reg   <= '0;
            err_reg       <= 1'b0;
            bus_req_reg   <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_addr_reg  <= '0;
            bus_be_reg    <= '0;
            bus_wdata_reg <= '0;
            rdata_reg     <= '0;
            cnt_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            func3_reg     <= func3_next;
            addr_lo_reg   <= addr_lo_next;
            err_reg       <= err_next;
            bus_req_reg   <= bus_req_next;
            bus_we_reg    <= bus_we_next;
            bus_addr_reg  <= bus_addr_next;
            bus_be_reg    <= bus_be_next;
            bus_wdata_reg <= bus_wdata_next;
            rdata_reg     <= rdata_next;
            cnt_reg       <= cnt_next;
        end
    end

    assign busy       = !is_idle;
    assign core_ready = (state_reg == RESP);
    assign core_err   = core_ready && err_reg;
    assign core_rdata = rdata_reg;
    assign bus_req    = bus_req_reg;
    assign bus_we     = bus_we_reg;
    assign bus_addr   = bus_addr_reg;
    assign bus_be     = bus_be_reg;
    assign bus_wdata  = bus_wdata_reg;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: driver issues accesses and acts as bus
// slave, pushing the expected core response; a monitor pops and compares.
module tb_data_mem_ctrl;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_rd, core_wr;
    logic [2:0]  core_func3;
    logic [31:0] core_addr, core_wdata;
    logic [31:0] core_rdata;
    logic        core_ready, core_err, busy;
    logic        bus_req, bus_we;
    logic [29:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata, bus_rdata;
    logic        bus_ack;

    data_mem_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .reset      (reset),
        .core_rd    (core_rd),
        .core_wr    (core_wr),
        .core_func3 (core_func3),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_ready (core_ready),
        .core_err   (core_err),
        .busy       (busy),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    logic [31:0] model_rdata = 32'h0;
    int          total = 0;
    int          bad   = 0;
    int          txn   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every completion pulse must match the oldest expected response
    always @(negedge clk) begin
        if (core_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("core_err", {31'd0, core_err}, {31'd0, mon_e.err});
                chk("core_rdata", core_rdata, mon_e.rdata);
                chk("ready_cycle", cyc, mon_e.cyc);
                txn++;
                $display("txn %0d: ready at cycle %0d err=%0b rdata=%h", txn, cyc, core_err, core_rdata);
            end
        end
    end

    // Reference load extraction from the width code, offset and bus word
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] word);
        logic [31:0] sh;
        int          v;
        sh = word >> (8 * off);
        case (f3)
            3'b000: begin v = int'(sh & 32'hFF);   if (v > 127)   v -= 256;   return 32'(v); end
            3'b001: begin v = int'(sh & 32'hFFFF); if (v > 32767) v -= 65536; return 32'(v); end
            3'b100: return sh & 32'hFF;
            3'b101: return sh & 32'hFFFF;
            default: return word;
        endcase
    endfunction

    // Issue one access; delay = REQ cycles before ack (>= T means never)
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rword, input int delay);
        logic        illegal, misal, fault;
        logic [1:0]  sz;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        int          exp_req, req_cnt, k;
        bit          done;
        exp_t        e;
        sz      = f3[1:0];
        illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (wr && f3[2]);
        misal   = (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00);
        fault   = (rd && wr) || illegal || misal;
        exp_be  = (sz == 2'd0) ? (4'b0001 << addr[1:0]) :
                  (sz == 2'd1) ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        exp_wd  = (sz == 2'd0) ? {4{wdata[7:0]}} :
                  (sz == 2'd1) ? {2{wdata[15:0]}} : wdata;
        k = cyc;
        if (fault) begin
            e.err = 1'b1; e.cyc = k + 1; exp_req = 0;
        end else if (delay < T) begin
            e.err = 1'b0; e.cyc = k + 2 + delay; exp_req = delay + 1;
            if (rd) model_rdata = ref_load(f3, addr[1:0], rword);
        end else begin
            e.err = 1'b1; e.cyc = k + T + 1; exp_req = T;
        end
        e.rdata = model_rdata;
        sbq.push_back(e);

        core_rd = rd; core_wr = wr; core_func3 = f3; core_addr = addr; core_wdata = wdata;
        @(posedge clk); #1;
        core_rd = 1'b0; core_wr = 1'b0;
        core_func3 = 3'($urandom); core_addr = $urandom; core_wdata = $urandom;

        req_cnt = 0;
        done    = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (bus_req) begin
                req_cnt++;
                chk("busy", {31'd0, busy}, 32'd1);
                chk("bus_we", {31'd0, bus_we}, {31'd0, wr});
                chk("bus_addr", {2'b00, bus_addr}, {2'b00, addr[31:2]});
                chk("bus_be", {28'd0, bus_be}, {28'd0, exp_be});
                if (wr) chk("bus_wdata", bus_wdata, exp_wd);
                if (req_cnt - 1 == delay) begin
                    bus_ack = 1'b1; bus_rdata = rword;
                end
            end
            if (core_ready) begin
                done = 1'b1;
                bus_ack = 1'b1;     // stray ack in RESP must be ignored
            end
            @(posedge clk); #1;
            bus_ack = 1'b0; bus_rdata = $urandom;
        end
        if (!done) chk("ready_seen", 32'd0, 32'd1);
        chk("req_cycles", req_cnt, exp_req);
    endtask

    logic [2:0] legal_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    initial begin
        int r;
        logic rd, wr;
        logic [2:0] f3;
        reset = 1'b0;
        core_rd = 0; core_wr = 0; core_func3 = 0; core_addr = 0; core_wdata = 0;
        bus_rdata = 0; bus_ack = 0;
        repeat (2) @(negedge clk);
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, core_ready}, 32'd0);
        chk("rst_err", {31'd0, core_err}, 32'd0);
        chk("rst_rdata", core_rdata, 32'd0);
        chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
        chk("rst_bus_addr", {2'b00, bus_addr}, 32'd0);
        chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80AABBCC, 1);
        access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80AABBCC, 0);
        access(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 2);
        access(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0);
        access(1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 0);
        access(0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 0);
        access(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
        access(1, 0, 3'b010, 32'h104, 32'h0, 32'h11111111, 10);
        access(1, 0, 3'b010, 32'h108, 32'h0, 32'hCAFEF00D, T - 1);
        access(1, 0, 3'b101, 32'h10A, 32'h0, 32'h8001_7FFF, 0);
        access(1, 0, 3'b001, 32'h10A, 32'h0, 32'h8001_7FFF, 0);

        // Reset in the middle of a REQ phase
        core_rd = 1; core_func3 = 3'b010; core_addr = 32'h300;
        @(posedge clk); #1;
        core_rd = 0;
        @(negedge clk);
        chk("mid_req_up", {31'd0, bus_req}, 32'd1);
        @(negedge clk); #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, core_ready}, 32'd0);
        model_rdata = 32'h0;
        chk("mid_rst_rdata", core_rdata, 32'd0);
        $display("reset asserted mid-transaction at cycle %0d", cyc);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        access(1, 0, 3'b010, 32'h400, 32'h0, 32'h0BADF00D, 0);

        // Randomized accesses
        for (int n = 0; n < 150; n++) begin
            r  = $urandom_range(0, 9);
            rd = (r <= 4) || (r == 9);
            wr = (r >= 5);
            f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : legal_f3[$urandom_range(0, 4)];
            access(rd, wr, f3, $urandom, $urandom, $urandom, $urandom_range(0, 6));
        end

        repeat (3) @(negedge clk);
        if (sbq.size() != 0) chk("sb_drained", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Load/store controller between the core's registered data-memory request outputs and the data-memory bus. It latches one core request, checks alignment, generates byte enables and write-lane shifting, runs a req/ack handshake with a watchdog, and returns sign- or zero-extended load data to the core's write-back mux together with a one-cycle ready pulse. One request is in flight at a time.

## Interface
- TIMEOUT_CYCLES, 16: maximum cycles in REQ without bus_ack before aborting; 0 disables the watchdog.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- core_rd  in  1  load request, sampled in IDLE (driven by the core's mem_rd_reg).
- core_wr  in  1  store request, sampled in IDLE (driven by the core's mem_wr_valid_reg).
- core_func3  in  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- core_addr  in  32  byte address.
- core_wdata  in  32  store data, right-aligned.
- core_rdata  out  32  extended load data; holds until the next load completes.
- core_ready  out  1  one-cycle completion pulse (feeds the core's data_ready).
- core_err  out  1  high together with core_ready when the access faulted.
- busy  out  1  high whenever state is not IDLE.
- bus_req  out  1  bus request; held until ack or timeout.
- bus_we  out  1  1 = write.
- bus_addr  out  30  word address (core_addr[31:2]).
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-shifted store data.
- bus_rdata  in  32  read word, valid in the bus_ack cycle.
- bus_ack  in  1  one-cycle completion from the bus.

## Operation
- States: IDLE, REQ, RESP.
- IDLE: when core_rd or core_wr is high, latch func3, addr and wdata.
  - Fault if both are high, if func3 is illegal (011, 110, 111, or 1xx on a store), or on misalignment (H with addr[0]=1; W with addr[1:0]≠00). On a fault go to RESP with err=1 and never assert bus_req.
  - Otherwise go to REQ.
- REQ: bus_req=1 with bus_we, bus_addr, bus_be and bus_wdata stable.
  - On bus_ack, capture bus_rdata and go to RESP.
  - If the watchdog is enabled and the counter reaches TIMEOUT_CYCLES, drop bus_req and go to RESP with err=1.
- RESP: core_ready=1 and core_err=err for exactly one cycle, then IDLE.
  - On a successful load, core_rdata updates in this cycle.
  - Stores and faults leave core_rdata unchanged.
- Byte enables:
  - B: 0001 shifted left by addr[1:0].
  - H: 0011 if addr[1]=0, else 1100.
  - W: 1111.
- bus_wdata: B replicates byte [7:0] on all lanes; H replicates [15:0] on both halves; W passes through.
- Load extraction: select the byte or half by addr[1:0]; B/H sign-extend; BU/HU zero-extend.
- Requests while busy are ignored. The core must not issue a new access until core_ready.

## Timing
- Reset values: all outputs 0, state IDLE, watchdog counter 0, core_rdata 0.
- Request seen in IDLE at edge N:
  - bus_req is high after edge N+1 and all bus outputs are registered.
  - If bus_ack is sampled high at edge M, core_ready is high during cycle M+1.
  - Best case latency is request → ready in 3 cycles (ack in the first REQ cycle).
- Fault path: request at edge N gives core_ready and core_err in the cycle after edge N+1.
- Timeout: bus_req is high for exactly TIMEOUT_CYCLES cycles. core_ready and core_err follow in the next cycle.
  - bus_ack arriving in the same cycle the count is reached wins: the access succeeds with err=0.
- bus_ack outside REQ is ignored.
- The watchdog counter clears on entry to REQ and saturates, so it has no wrap.
- Reset asserted mid-transaction: immediate return to IDLE, bus_req=0, and no core_ready pulse.

## Structure
- mem_pkg holds:
  - func3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state encoding (IDLE=2'd0, REQ=2'd1, RESP=2'd2);
  - byte-enable constants.
- One combinational sub-module, mem_align, computes bus_be, bus_wdata, the alignment fault and load extraction from func3/addr/data. data_mem_ctrl keeps the FSM, registers and watchdog.

## Test plan
- LW at 0x100, bus_rdata=0xDEADBEEF with ack in the first REQ cycle → bus_be=1111, bus_addr=0x40, core_rdata=0xDEADBEEF, ready 3 cycles after the request, err=0.
- LB at 0x103, rdata=0x80AABBCC → be=1000, core_rdata=0xFFFFFF80. LBU at the same address → core_rdata=0x00000080.
- SH at 0x202, wdata=0x1234ABCD → bus_we=1, be=1100, bus_wdata=0xABCDABCD, core_rdata unchanged.
- LW at 0x101 → no bus_req, core_ready and core_err pulse in the second cycle after the request. core_rd and core_wr both high → same response.
- TIMEOUT_CYCLES=4 with ack never asserted → bus_req high for 4 cycles, then ready+err. Ack in the 4th cycle → success with err=0.
- Reset pulled low while in REQ → bus_req=0 and busy=0 immediately, no ready pulse. After release, a fresh LW completes normally.
